// File: rtl/logic_acc.sv
// Sequential bitwise accumulator: one command per in handshake, registered result per out handshake.
// Each accumulator bit is computed by its own lane instance; no bit depends on a neighbour.

module logic_acc_lane (
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       y
);
    always_comb begin
        y = a;
        case (op)
            3'd0:    y = a ^ b;
            3'd1:    y = a & b;
            3'd2:    y = a | b;
            3'd3:    y = ~(a | b);
            3'd4:    y = b;
            3'd5:    y = 1'b0;
            default: y = a;   // reserved codes leave the bit untouched
        endcase
    end
endmodule

module logic_acc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Err,
    output logic [7:0]       OpCount
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] b;
    } cmd_t;

    state_t           state, state_nxt;
    cmd_t             cmd_q;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic             zero_q, err_q, out_valid_q;
    logic [7:0]       cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic_acc_lane u_lane (
            .op (cmd_q.op),
            .a  (acc[i]),
            .b  (cmd_q.b[i]),
            .y  (acc_nxt[i])
        );
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_q       <= '0;
            acc         <= '0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt         <= 8'd0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt == RESP);
            if (state == IDLE && in_valid) begin
                cmd_q.op <= op;
                cmd_q.b  <= B;
            end
            // acc, Zero and Err only move in EXEC, so they hold steady through a RESP stall
            if (state == EXEC) begin
                acc    <= acc_nxt;
                zero_q <= (acc_nxt == '0);
                err_q  <= cmd_q.op[2] & cmd_q.op[1];
            end
            if (state == RESP && out_ready) cnt <= cnt + 8'd1;
        end
    end

    assign out_valid = out_valid_q;
    assign Result    = acc;
    assign Zero      = zero_q;
    assign Err       = err_q;
    assign OpCount   = cnt;
endmodule

// File: tb/tb_logic_acc.sv
// Self-checking bench for logic_acc: randomized commands checked against a word-level model.

module tb_logic_acc;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] B;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] Result;
    logic       Zero;
    logic       Err;
    logic [7:0] OpCount;

    int checks = 0;
    int errors = 0;

    logic [3:0] acc_m;
    logic       err_m;
    int         cnt_m;

    logic_acc #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .Zero      (Zero),
        .Err       (Err),
        .OpCount   (OpCount)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_op(input logic [2:0] o, input logic [3:0] a, input logic [3:0] b);
        case (o)
            3'd0:    return a ^ b;
            3'd1:    return a & b;
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return b;
            3'd5:    return 4'd0;
            default: return a;
        endcase
    endfunction

    // Holds rst over two rising edges; returns at a falling edge with reset released.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        acc_m = 4'd0; err_m = 1'b0; cnt_m = 0;
        checks++; if (Result !== 4'd0) begin errors++; $display("FAIL %s_result: got %b exp 0000", tag, Result); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL %s_zero: got %b exp 1", tag, Zero); end
        checks++; if (Err !== 1'b0) begin errors++; $display("FAIL %s_err: got %b exp 0", tag, Err); end
        checks++; if (OpCount !== 8'd0) begin errors++; $display("FAIL %s_opcount: got %0d exp 0", tag, OpCount); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_out_valid: got %b exp 0", tag, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: got %b exp 1", tag, in_ready); end
    endtask

    // Called at a falling edge in IDLE; returns at a falling edge back in IDLE.
    task automatic send(input logic [2:0] o, input logic [3:0] b, input int stall);
        logic [3:0] hold;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b exp 1", in_ready); end
        in_valid = 1'b1; op = o; B = b;
        out_ready = (stall == 0);
        @(negedge clk);
        // operand bus changes after accept; the latched copy must be used
        in_valid = 1'b0; op = 3'($urandom); B = 4'($urandom);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exec_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL exec_in_ready: got %b exp 0", in_ready); end
        if (o < 3'd6) begin acc_m = model_op(o, acc_m, b); err_m = 1'b0; end
        else err_m = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL resp_out_valid: got %b exp 1", out_valid); end
        checks++; if (Result !== acc_m) begin errors++; $display("FAIL resp_result: op %0d got %b exp %b", o, Result, acc_m); end
        checks++; if (Zero !== (acc_m == 4'd0)) begin errors++; $display("FAIL resp_zero: got %b exp %b", Zero, acc_m == 4'd0); end
        checks++; if (Err !== err_m) begin errors++; $display("FAIL resp_err: got %b exp %b", Err, err_m); end
        hold = Result;
        for (int k = 0; k < stall; k++) begin
            in_valid = ~in_valid; op = 3'($urandom); B = 4'($urandom);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b exp 1", out_valid); end
            checks++; if (Result !== hold) begin errors++; $display("FAIL stall_result: got %b exp %b", Result, hold); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b exp 0", in_ready); end
            checks++; if (OpCount !== 8'(cnt_m)) begin errors++; $display("FAIL stall_opcount: got %0d exp %0d", OpCount, cnt_m); end
        end
        if (stall > 0) begin in_valid = 1'b0; out_ready = 1'b1; end
        @(negedge clk);
        out_ready = 1'b0;
        cnt_m = (cnt_m + 1) % 256;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL done_out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL done_in_ready: got %b exp 1", in_ready); end
        checks++; if (OpCount !== 8'(cnt_m)) begin errors++; $display("FAIL done_opcount: got %0d exp %0d", OpCount, cnt_m); end
    endtask

    task automatic test_reset();
        do_reset("rst_idle");
        send(3'd4, 4'b1111, 0);
        in_valid = 1'b1; op = 3'd0; B = 4'b0101;
        @(negedge clk);
        do_reset("rst_exec");
        in_valid = 1'b1; op = 3'd4; B = 4'b0110;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        do_reset("rst_resp");
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_no_response: got %b exp 0", out_valid); end
    endtask

    task automatic test_op_sequence();
        logic [2:0] ops [5] = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
        logic [3:0] bs  [5] = '{4'b1010, 4'b0110, 4'b1001, 4'b0100, 4'b0001};
        logic [3:0] exp [5] = '{4'b1010, 4'b1100, 4'b1000, 4'b1100, 4'b0010};
        do_reset("seq_rst");
        for (int i = 0; i < 5; i++) begin
            send(ops[i], bs[i], 0);
            checks++; if (Result !== exp[i]) begin errors++; $display("FAIL seq_result%0d: got %b exp %b", i, Result, exp[i]); end
        end
        checks++; if (OpCount !== 8'd5) begin errors++; $display("FAIL seq_opcount: got %0d exp 5", OpCount); end
    endtask

    task automatic test_clear();
        send(3'd4, 4'b1111, 0);
        send(3'd5, 4'($urandom), 0);
        checks++; if (Result !== 4'd0) begin errors++; $display("FAIL clear_result: got %b exp 0000", Result); end
        checks++; if (Zero !== 1'b1) begin errors++; $display("FAIL clear_zero: got %b exp 1", Zero); end
    endtask

    task automatic test_reserved();
        send(3'd4, 4'b0101, 0);
        send(3'd6, 4'b0011, 0);
        checks++; if (Result !== 4'b0101) begin errors++; $display("FAIL rsv_result: got %b exp 0101", Result); end
        checks++; if (Err !== 1'b1) begin errors++; $display("FAIL rsv_err: got %b exp 1", Err); end
        send(3'd7, 4'b1111, 0);
        send(3'd2, 4'b0000, 0);
        checks++; if (Err !== 1'b0) begin errors++; $display("FAIL rsv_err_clear: got %b exp 0", Err); end
    endtask

    task automatic test_backpressure();
        send(3'd4, 4'($urandom), 5);
        for (int i = 0; i < 6; i++) send(3'($urandom_range(0, 7)), 4'($urandom), int'($urandom_range(0, 4)));
    endtask

    task automatic test_wrap_and_midreset();
        do_reset("wrap_rst");
        for (int i = 0; i < 256; i++) send(3'($urandom_range(0, 7)), 4'($urandom), 0);
        checks++; if (OpCount !== 8'd0) begin errors++; $display("FAIL wrap_opcount: got %0d exp 0", OpCount); end
        send(3'd4, 4'b1011, 0);
        in_valid = 1'b1; op = 3'd2; B = 4'b0100;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid%0d: got %b exp 0", k, out_valid); end
            checks++; if (Result !== 4'd0) begin errors++; $display("FAIL midrst_result%0d: got %b exp 0000", k, Result); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; B = 4'd0; out_ready = 1'b0;
        acc_m = 4'd0; err_m = 1'b0; cnt_m = 0;
        test_reset();
        test_op_sequence();
        test_clear();
        test_reserved();
        test_backpressure();
        test_wrap_and_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_acc.md
# logic_acc

Sequential 4-bit logic accumulator for the ALU datapath. It accepts one command per valid/ready handshake and applies the selected bitwise operation (XOR, AND, OR, NOR, load, clear) between an internal accumulator and the command operand. It returns the registered result on a second valid/ready handshake. Upstream control issues the commands; the result port feeds the ALU result bus.

## Interface
- `WIDTH`, default 4: operand, accumulator and result width.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: command present.
- `in_ready` output 1: block can accept a command.
- `op` input 3: operation code, sampled on accept.
- `B` input WIDTH: operand, sampled on accept.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer takes the result.
- `Result` output WIDTH: accumulator value after the command.
- `Zero` output 1: `Result == 0`.
- `Err` output 1: the command carried a reserved op code.
- `OpCount` output 8: count of completed commands.

## Operation
- States: `IDLE`, `EXEC`, `RESP`.
- `IDLE`: `in_ready`=1. If `in_valid` is high, the command is accepted. `op` and `B` are latched into internal registers and the state moves to `EXEC`.
- `EXEC`: `in_ready`=0. The accumulator is updated from the latched op, then the state moves to `RESP`. Op codes:
  - 0: acc ^ B
  - 1: acc & B
  - 2: acc | B
  - 3: ~(acc | B)
  - 4: load, acc = B
  - 5: clear, acc = 0
  - 6, 7: reserved. acc is unchanged and `Err` is set to 1.
- For ops 0–5, `Err` is set to 0.
- All ops are bitwise on WIDTH bits. There is no carry and no bit crosses a lane.
- `RESP`: `out_valid`=1 and `Result`=acc. `Zero` and `Err` are valid.
  - `Result`, `Zero` and `Err` stay stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1, `OpCount` increments and the state returns to `IDLE`.
  - `OpCount` wraps from 255 to 0. Reserved ops are counted too.
- `in_valid` is ignored outside `IDLE`. Upstream holds the command until `in_ready`=1.
- Reset values:
  - acc and `Result` = 0
  - `Zero` = 1
  - `Err` = 0
  - `OpCount` = 0
  - `out_valid` = 0
  - `in_ready` = 1 (state `IDLE`)
- Reset in any state discards the in-flight command and produces no response.

## Timing
- Command accepted at edge N (`IDLE`, `in_valid`=1).
- Edge N+1 updates acc in `EXEC`.
- `out_valid`=1 from after edge N+1 through the cycle ending at edge N+2. It is visible in the cycle ending at edge N+2.
- If `out_ready` is already high, the response completes at edge N+2 and `in_ready`=1 in the following cycle.
- Minimum interval is 3 cycles per command. There are no bubbles beyond the `out_ready` stall.
- Outputs are all registered. Nothing is combinational from inputs to outputs except the state-derived `in_ready`.
- `out_valid` never drops without a handshake, except on `rst`.
- If `rst` and a handshake occur on the same edge, `rst` wins: `OpCount` does not increment.

## Test plan
- **Reset defaults.** Assert `rst` for 2 cycles in every state. Required: `Result`=0, `Zero`=1, `Err`=0, `OpCount`=0, `out_valid`=0, `in_ready`=1.
- **Op sequence.** Send load `B`=4'b1010, then XOR `B`=4'b0110, AND 4'b1001, OR 4'b0100, NOR 4'b0001, with `out_ready` held at 1. Required results: 1010, 1100, 1000, 1100, 0010. Each `out_valid` pulse arrives 2 edges after its accept. `OpCount` ends at 5.
- **Clear.** Send clear (op 5) after acc=4'b1111. Required: `Result`=0, `Zero`=1.
- **Reserved op.** Send op=6 with `B`=4'b0011 while acc=4'b0101. Required: `Result`=4'b0101, `Err`=1. The next valid op clears `Err`.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles in `RESP` while `in_valid` toggles. Required: `Result` is stable, `in_ready`=0, no command is accepted and `OpCount` is unchanged until `out_ready` rises.
- **Counter wrap and mid-operation reset.** Complete 256 commands. Required: `OpCount` reads 0. Then assert `rst` during `EXEC`. Required: no `out_valid`, acc=0.
